// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU completion FIFOs merged onto one registered common data bus broadcast.
// Define CDB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest FU index wins).
module cdb_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned FU_W  = $clog2(NUM_FU)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic [NUM_FU-1:0]        fu_valid_i,
  output logic [NUM_FU-1:0]        fu_ready_o,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag_i,
  input  logic [NUM_FU*DATA_W-1:0] fu_data_i,
  output logic                     cdb_en_o,
  output logic [TAG_W-1:0]         cdb_reg_addr_o,
  output logic [DATA_W-1:0]        cdb_data_o,
  output logic [FU_W-1:0]          cdb_fu_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [NUM_FU-1:0] w_nonempty;
  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_pop;
  entry_t            w_heads [NUM_FU];
  logic              w_gnt_vld;
  logic [FU_W-1:0]   w_gnt_idx;

  logic              r_cdb_en;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic [FU_W-1:0]   r_cdb_fu;

`ifdef CDB_RR_EN
  logic [FU_W-1:0]   r_ptr;
`endif

  // Per-FU completion FIFO; ready is a registered copy of "not full".
  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic [TAG_W-1:0]   w_tag;
    logic [DATA_W-1:0]  w_data;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_tag         = fu_tag_i[g*TAG_W +: TAG_W];
    assign w_data        = fu_data_i[g*DATA_W +: DATA_W];
    assign w_nonempty[g] = (r_cnt != '0);
    // Tag 0 (x0) handshakes normally but is never stored.
    assign w_push[g]     = fu_valid_i[g] & r_ready & ~flush_i & (w_tag != '0);
    assign w_pop[g]      = w_gnt_vld & (w_gnt_idx == FU_W'(g));
    assign w_cnt_nxt     = r_cnt + CNT_W'(w_push[g]) - CNT_W'(w_pop[g]);
    assign w_heads[g]    = r_mem[r_rptr];
    assign fu_ready_o[g] = r_ready;

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_cnt   <= '0;
        r_ready <= 1'b1;
      end else if (flush_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_cnt   <= '0;
        r_ready <= 1'b1;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop[g])  r_rptr <= r_rptr + PTR_W'(1);
        r_cnt   <= w_cnt_nxt;
        r_ready <= (w_cnt_nxt != CNT_W'(DEPTH));
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push[g]) r_mem[r_wptr] <= {w_tag, w_data};
    end
  end

  // Grant search: later iterations overwrite earlier ones, so the last candidate checked wins.
  always_comb begin
    int unsigned j;
    j         = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (!flush_i) begin
      for (int unsigned n = 0; n < NUM_FU; n++) begin
`ifdef CDB_RR_EN
        j = (32'(r_ptr) + NUM_FU - n) % NUM_FU;
`else
        j = NUM_FU - 1 - n;
`endif
        if (w_nonempty[FU_W'(j)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = FU_W'(j);
        end
      end
    end
  end

`ifdef CDB_RR_EN
  // Last-granted pointer; moves only on a grant and survives flush.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_ptr <= FU_W'(NUM_FU - 1);
    end else if (w_gnt_vld) begin
      r_ptr <= w_gnt_idx;
    end
  end
`endif

  // Broadcast register; payload holds its value on idle cycles.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cdb_en   <= 1'b0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
      r_cdb_fu   <= '0;
    end else begin
      r_cdb_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_cdb_tag  <= w_heads[w_gnt_idx].tag;
        r_cdb_data <= w_heads[w_gnt_idx].data;
        r_cdb_fu   <= w_gnt_idx;
      end
    end
  end

  assign cdb_en_o       = r_cdb_en;
  assign cdb_reg_addr_o = r_cdb_tag;
  assign cdb_data_o     = r_cdb_data;
  assign cdb_fu_o       = r_cdb_fu;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the functional units (ALU, LSU, MUL, BR) and broadcasts one result per cycle on the common data bus (CDB). The CDB feeds rename/decode (`cdb_en_i`, `cdb_reg_addr_i`), the reservation stations and the register file. This block is the transmitting end of the CDB. Each FU has a small completion FIFO, so an FU stalls only when its own FIFO is full.

## Interface
- `NUM_FU`, 4: number of FU completion ports; index 0=ALU, 1=LSU, 2=MUL, 3=BR.
- `TAG_W`, 5: physical destination register address width.
- `DATA_W`, 32: result width.
- `DEPTH`, 2: entries per FU completion FIFO; power of two, ≥2.

- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  synchronous pipeline flush.
- `fu_valid_i`  in  NUM_FU  per-FU result valid.
- `fu_ready_o`  out  NUM_FU  per-FU FIFO can accept.
- `fu_tag_i`  in  NUM_FU*TAG_W  packed destination tags; FU k occupies bits [k*TAG_W +: TAG_W].
- `fu_data_i`  in  NUM_FU*DATA_W  packed results, same packing rule.
- `cdb_en_o`  out  1  broadcast valid; registered.
- `cdb_reg_addr_o`  out  TAG_W  broadcast tag; registered.
- `cdb_data_o`  out  DATA_W  broadcast data; registered.
- `cdb_fu_o`  out  $clog2(NUM_FU)  index of the FU that produced the broadcast; registered.

## Operation
- **FIFOs**
  - Each FU has a FIFO holding {tag, data} with a count of 0..DEPTH.
  - `fu_ready_o[k] = (count_k != DEPTH)`. It depends only on registered state, never on the current grant.
  - Enqueue when `fu_valid_i[k] & fu_ready_o[k]`.
  - A full FIFO does not accept input in the same cycle it dequeues.
- **Tag 0:** a handshake with tag 0 completes normally but the entry is discarded (not stored, no broadcast), because x0 is never renamed.
- **Arbitration:** each cycle, one grant goes to a non-empty FIFO head. The granted entry is dequeued and loaded into the output register.
  - No request in a cycle: `cdb_en_o` deasserts next cycle and the data/tag/fu outputs hold their previous values.
- **Simultaneous enqueue/dequeue on one FIFO (not full):** count is unchanged and both pointers advance, wrapping modulo DEPTH.
- **Flush:** when `flush_i`=1, at the next edge all FIFO counts and pointers clear and `cdb_en_o` goes to 0.
  - Inputs presented in the flush cycle are dropped.
  - No grant occurs in the flush cycle.
  - The arbitration pointer is retained.
- **Reset values:** `cdb_en_o`=0, `cdb_reg_addr_o`=0, `cdb_data_o`=0, `cdb_fu_o`=0, all counts=0 (so `fu_ready_o` is all ones), arbitration pointer=NUM_FU-1.
  - Asserting reset mid-operation discards all pending entries immediately.

## Timing
- Result accepted at the end of cycle t → earliest `cdb_en_o`=1 in cycle t+2, with no combinational input-to-CDB path.
- Sustained throughput: one broadcast per cycle while any FIFO is non-empty.
- A single FU streaming alone with DEPTH=2 runs at full rate: `fu_ready_o` stays high, since it enqueues and dequeues every cycle.
- `cdb_en_o` is a one-cycle pulse per entry. Consumers sample it every cycle and there is no backpressure from the CDB.

## Configuration
- `CDB_RR_EN` defined: round-robin arbitration.
  - The search starts at (last granted + 1) mod NUM_FU.
  - The pointer updates only on a grant.
  - No FU waits more than NUM_FU-1 grants once at its FIFO head.
- `CDB_RR_EN` undefined: fixed priority, lowest index wins (ALU > LSU > MUL > BR). The pointer register is removed.

## Test plan
- Reset, then ALU valid for one cycle with tag 7, data 0x12345678 → `cdb_en_o`=1 exactly two cycles later with tag 7, data 0x12345678, fu 0; then `cdb_en_o`=0.
- All four FUs valid in the same cycle with tags 1..4 → four consecutive broadcasts; under `CDB_RR_EN` in order 1,2,3,4 from reset, otherwise the same order. Every `fu_ready_o` stays high throughout.
- MUL held valid for 6 cycles while ALU is valid continuously, without `CDB_RR_EN` → ALU owns the CDB, MUL's FIFO fills, and `fu_ready_o[2]`=0 after 2 accepts. With `CDB_RR_EN`, the grants alternate ALU/MUL.
- LSU sends tag 0 then tag 9 → only tag 9 is broadcast, and no `cdb_en_o` pulse occurs for tag 0.
- Fill all FIFOs (8 entries), assert `flush_i` for one cycle → `cdb_en_o`=0 from the next cycle, all `fu_ready_o`=1, and no stale tags appear afterward.
- Drop `reset_i` asynchronously mid-burst → outputs are zero immediately, before the next clock edge.
